dcache_fill_ctrl: RTL

// - Miss-fill writer for the direct-mapped cachemem: accepts miss requests, issues BUS_LOAD to memory, matches tagged returns.
// - Writes returned blocks into cachemem through its wr_en/wr_idx/wr_tag/wr_data port.
// - Sits between the cache lookup logic (rd_hit miss) and the memory bus; up to NUM_MSHR misses in flight.

---
 rtl/dcache_fill_ctrl_pkg.sv | 59 +++++
 rtl/dcache_fill_ctrl_if.sv | 43 ++++
 rtl/dcache_fill_ctrl_fifo.sv | 49 ++++
 rtl/dcache_fill_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_fill_ctrl_pkg.sv
// cache_pkg: bus command, miss-entry types and address-field helpers
// shared by the fill controller and cachemem.
package cache_pkg;

    localparam int ADDR_BITS    = 32;
    localparam int NUM_LINES    = 64;
    localparam int OFF_BITS     = 3;
    localparam int IDX_BITS     = $clog2(NUM_LINES);
    localparam int TAG_BITS     = ADDR_BITS - IDX_BITS - OFF_BITS;
    localparam int BLK_BITS     = ADDR_BITS - OFF_BITS;
    localparam int DATA_BITS    = 64;
    localparam int NUM_MSHR     = 4;
    localparam int MSHR_BITS    = $clog2(NUM_MSHR);
    localparam int MEM_TAG_BITS = 4;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e             state;
        logic [BLK_BITS-1:0]     blk_addr;
        logic [MEM_TAG_BITS-1:0] mem_tag;
        logic                    prefetch;
    } mshr_entry_t;

    localparam mshr_entry_t MSHR_RESET = '{
        state:    FREE,
        blk_addr: '0,
        mem_tag:  '0,
        prefetch: 1'b0
    };

    function automatic logic [IDX_BITS-1:0] blk_idx(
        input logic [BLK_BITS-1:0] blk
    );
        return IDX_BITS'(blk);
    endfunction

    function automatic logic [TAG_BITS-1:0] blk_tag(
        input logic [BLK_BITS-1:0] blk
    );
        return TAG_BITS'(blk >> IDX_BITS);
    endfunction

    function automatic logic [ADDR_BITS-1:0] blk_to_addr(
        input logic [BLK_BITS-1:0] blk
    );
        return {blk, {OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_fill_ctrl_if.sv
// dcache_fill_ctrl_if: miss request, memory bus, cachemem write port
// and fill notify bundled for the fill controller.
interface dcache_fill_ctrl_if;
    import cache_pkg::*;

    logic                    miss_valid;
    logic [ADDR_BITS-1:0]    miss_addr;
    logic                    miss_ready;

    BUS_COMMAND              proc2mem_command;
    logic [ADDR_BITS-1:0]    proc2mem_addr;
    logic [MEM_TAG_BITS-1:0] mem2proc_response;
    logic [DATA_BITS-1:0]    mem2proc_data;
    logic [MEM_TAG_BITS-1:0] mem2proc_tag;

    logic                    wr_en;
    logic [IDX_BITS-1:0]     wr_idx;
    logic [TAG_BITS-1:0]     wr_tag;
    logic [DATA_BITS-1:0]    wr_data;

    logic                    fill_valid;
    logic [ADDR_BITS-1:0]    fill_addr;
    logic                    busy;

    modport master (
        input  miss_valid, miss_addr,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output miss_ready,
        output proc2mem_command, proc2mem_addr,
        output wr_en, wr_idx, wr_tag, wr_data,
        output fill_valid, fill_addr, busy
    );

    modport slave (
        output miss_valid, miss_addr,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  miss_ready,
        input  proc2mem_command, proc2mem_addr,
        input  wr_en, wr_idx, wr_tag, wr_data,
        input  fill_valid, fill_addr, busy
    );

endinterface

// File: rtl/dcache_fill_ctrl_fifo.sv
// mshr_issue_fifo: circular FIFO of miss-entry indices in allocation
// order; a demand and its prefetch may be pushed together.
module mshr_issue_fifo
    import cache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_push_a,
    input  logic [MSHR_BITS-1:0] i_idx_a,
    input  logic                 i_push_b,
    input  logic [MSHR_BITS-1:0] i_idx_b,
    input  logic                 i_pop,
    output logic [MSHR_BITS-1:0] o_head,
    output logic                 o_empty
);

    logic [MSHR_BITS-1:0] r_slot [NUM_MSHR];
    logic [MSHR_BITS-1:0] r_rd_ptr;
    logic [MSHR_BITS-1:0] r_wr_ptr;
    logic [MSHR_BITS:0]   r_count;
    logic [MSHR_BITS-1:0] w_wr_ptr_b;

    // second push lands behind the first when both fire
    assign w_wr_ptr_b = r_wr_ptr + MSHR_BITS'(i_push_a);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + MSHR_BITS'(i_pop);
            r_wr_ptr <= w_wr_ptr_b + MSHR_BITS'(i_push_b);
            r_count  <= r_count
                      + (MSHR_BITS+1)'(i_push_a)
                      + (MSHR_BITS+1)'(i_push_b)
                      - (MSHR_BITS+1)'(i_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push_a) r_slot[r_wr_ptr]   <= i_idx_a;
        if (i_push_b) r_slot[w_wr_ptr_b] <= i_idx_b;
    end

    assign o_head  = r_slot[r_rd_ptr];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/dcache_fill_ctrl.sv
// dcache_fill_ctrl: miss-fill writer for the direct-mapped cachemem.
// Define DCACHE_FILL_PREFETCH_EN to also fetch the next block on demand misses.
module dcache_fill_ctrl
    import cache_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    dcache_fill_ctrl_if.master bus
);

    mshr_entry_t r_mshr     [NUM_MSHR];
    mshr_entry_t w_mshr_nxt [NUM_MSHR];

    logic [BLK_BITS-1:0]  w_miss_blk;
    logic                 w_merge;
    logic [MSHR_BITS-1:0] w_merge_idx;
    logic                 w_free_any;
    logic [MSHR_BITS-1:0] w_free_idx;
    logic                 w_busy;
    logic                 w_ret_hit;
    logic [MSHR_BITS-1:0] w_ret_idx;
    logic                 w_ret_demand;
    logic                 w_alloc;
    logic                 w_pf_alloc;
    logic [MSHR_BITS-1:0] w_pf_idx;
    logic                 w_fifo_empty;
    logic [MSHR_BITS-1:0] w_head;
    logic                 w_issue;
    logic                 w_issue_ack;

    logic                 r_wr_en;
    logic [IDX_BITS-1:0]  r_wr_idx;
    logic [TAG_BITS-1:0]  r_wr_tag;
    logic [DATA_BITS-1:0] r_wr_data;
    logic                 r_fill_valid;
    logic [ADDR_BITS-1:0] r_fill_addr;

    assign w_miss_blk = BLK_BITS'(bus.miss_addr >> OFF_BITS);

    // descending scan so the lowest matching index wins
    always_comb begin
        w_merge     = 1'b0;
        w_merge_idx = '0;
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        w_busy      = 1'b0;
        w_ret_hit   = 1'b0;
        w_ret_idx   = '0;
        for (int i = NUM_MSHR-1; i >= 0; i--) begin
            if (r_mshr[i].state != FREE) begin
                w_busy = 1'b1;
                if (r_mshr[i].blk_addr == w_miss_blk) begin
                    w_merge     = 1'b1;
                    w_merge_idx = MSHR_BITS'(i);
                end
            end else begin
                w_free_any = 1'b1;
                w_free_idx = MSHR_BITS'(i);
            end
            if (r_mshr[i].state == WAIT &&
                bus.mem2proc_tag != '0 &&
                r_mshr[i].mem_tag == bus.mem2proc_tag) begin
                w_ret_hit = 1'b1;
                w_ret_idx = MSHR_BITS'(i);
            end
        end
    end

    assign w_alloc = bus.miss_valid & ~w_merge & w_free_any;

`ifdef DCACHE_FILL_PREFETCH_EN
    logic [BLK_BITS-1:0] w_pf_blk;
    logic                w_pf_present;
    logic                w_pf_free;

    assign w_pf_blk = w_miss_blk + 1'b1;

    always_comb begin
        w_pf_present = 1'b0;
        w_pf_free    = 1'b0;
        w_pf_idx     = '0;
        for (int i = NUM_MSHR-1; i >= 0; i--) begin
            if (r_mshr[i].state != FREE) begin
                if (r_mshr[i].blk_addr == w_pf_blk) w_pf_present = 1'b1;
            end else if (MSHR_BITS'(i) != w_free_idx) begin
                w_pf_free = 1'b1;
                w_pf_idx  = MSHR_BITS'(i);
            end
        end
    end

    assign w_pf_alloc = w_alloc & ~w_pf_present & w_pf_free;

    // a demand merging into a prefetch that returns now still gets notified
    assign w_ret_demand = ~r_mshr[w_ret_idx].prefetch
                        | (bus.miss_valid & w_merge
                           & (w_merge_idx == w_ret_idx));
`else
    assign w_pf_alloc   = 1'b0;
    assign w_pf_idx     = '0;
    assign w_ret_demand = ~r_mshr[w_ret_idx].prefetch;
`endif

    mshr_issue_fifo u_issue_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push_a (w_alloc),
        .i_idx_a  (w_free_idx),
        .i_push_b (w_pf_alloc),
        .i_idx_b  (w_pf_idx),
        .i_pop    (w_issue_ack),
        .o_head   (w_head),
        .o_empty  (w_fifo_empty)
    );

    assign w_issue     = ~w_fifo_empty;
    assign w_issue_ack = w_issue & (bus.mem2proc_response != '0);

    always_comb begin
        w_mshr_nxt = r_mshr;
        if (w_issue_ack) begin
            w_mshr_nxt[w_head].state   = WAIT;
            w_mshr_nxt[w_head].mem_tag = bus.mem2proc_response;
        end
        if (w_ret_hit) begin
            w_mshr_nxt[w_ret_idx].state = FREE;
        end
        if (w_alloc) begin
            w_mshr_nxt[w_free_idx].state    = PEND;
            w_mshr_nxt[w_free_idx].blk_addr = w_miss_blk;
            w_mshr_nxt[w_free_idx].mem_tag  = '0;
            w_mshr_nxt[w_free_idx].prefetch = 1'b0;
        end
`ifdef DCACHE_FILL_PREFETCH_EN
        if (w_pf_alloc) begin
            w_mshr_nxt[w_pf_idx].state    = PEND;
            w_mshr_nxt[w_pf_idx].blk_addr = w_pf_blk;
            w_mshr_nxt[w_pf_idx].mem_tag  = '0;
            w_mshr_nxt[w_pf_idx].prefetch = 1'b1;
        end
        if (bus.miss_valid && w_merge) begin
            w_mshr_nxt[w_merge_idx].prefetch = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_mshr[i] <= MSHR_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_mshr[i] <= w_mshr_nxt[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_en      <= 1'b0;
            r_wr_idx     <= '0;
            r_wr_tag     <= '0;
            r_wr_data    <= '0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
        end else begin
            r_wr_en      <= w_ret_hit;
            r_fill_valid <= w_ret_hit & w_ret_demand;
            if (w_ret_hit) begin
                r_wr_idx    <= blk_idx(r_mshr[w_ret_idx].blk_addr);
                r_wr_tag    <= blk_tag(r_mshr[w_ret_idx].blk_addr);
                r_wr_data   <= bus.mem2proc_data;
                r_fill_addr <= blk_to_addr(r_mshr[w_ret_idx].blk_addr);
            end
        end
    end

    assign bus.miss_ready       = w_merge | w_free_any;
    assign bus.proc2mem_command = w_issue ? BUS_LOAD : BUS_NONE;
    assign bus.proc2mem_addr    = w_issue
                                ? blk_to_addr(r_mshr[w_head].blk_addr)
                                : '0;
    assign bus.wr_en            = r_wr_en;
    assign bus.wr_idx           = r_wr_idx;
    assign bus.wr_tag           = r_wr_tag;
    assign bus.wr_data          = r_wr_data;
    assign bus.fill_valid       = r_fill_valid;
    assign bus.fill_addr        = r_fill_addr;
    assign bus.busy             = w_busy;

endmodule
